cla4: RTL and testbench
=======================

// Module: cla4
// PURPOSE
//   4-bit carry-lookahead adder slice with registered outputs.
//   Computes S = A + B + Ci, carry-out Co, and group propagate/generate (PG/GG)
//   so several slices can be cascaded under a second-level lookahead unit.
//   Lookahead core is combinational; one output register stage sits between it and the ports.
// PARAMETERS
//   None. Width is fixed at 4 bits.
// PORTS
//   clk       input   1  system clock; all state changes on rising edge
//   rst_n     input   1  asynchronous, active-low reset
//   in_valid  input   1  capture enable; operands sampled when high
//   A         input   4  operand A, unsigned
//   B         input   4  operand B, unsigned
//   Ci        input   1  carry-in
//   S         output  4  registered sum bits [3:0]
//   Co        output  1  registered carry-out of bit 3
//   PG        output  1  registered group propagate
//   GG        output  1  registered group generate
//   out_valid output  1  high for one cycle after each captured operation
// BEHAVIOUR
//   Reset:
//   - rst_n low asynchronously clears S=4'b0000, Co=0, PG=0, GG=0, out_valid=0.
//   - Outputs stay cleared while rst_n is low.
//   - Released synchronously in effect: first capture happens at the first rising edge with rst_n high.
//   Core (combinational, per bit i=0..3):
//   - Pi = Ai ^ Bi; Gi = Ai & Bi.
//   - C0 = Ci.
//   - C1 = G0 | P0C0.
//   - C2 = G1 | P1G0 | P1P0C0.
//   - C3 = G2 | P2G1 | P2P1G0 | P2P1P0C0.
//   - Co = G3 | P3G2 | P3P2G1 | P3P2P1G0 | P3P2P1P0C0.
//   - Carries are expanded sum-of-products; no rippling between bits.
//   - Si = Pi ^ Ci.
//   - PG = P3&P2&P1&P0.
//   - GG = G3 | P3G2 | P3P2G1 | P3P2P1G0.
//   - PG and GG are independent of Ci.
//   - Consistency: Co == GG | (PG & Ci) always holds.
//   Register stage:
//   - On a rising edge with in_valid=1: S/Co/PG/GG load the core results; out_valid<=1.
//   - On a rising edge with in_valid=0: S/Co/PG/GG hold; out_valid<=0.
//   - Latency is exactly 1 clock.
//   - Back-to-back in_valid gives one result per cycle.
//   - There is no backpressure.
//   Boundaries:
//   - {Co,S} is the full 5-bit sum and never truncates; 15+15+1 = 31 -> S=1111, Co=1.
//   - PG=1 means Ci propagates to Co: 1010+0101 -> Co tracks Ci.
//   - If rst_n asserts mid-operation, the pending result is discarded and out_valid=0.
//   - X or Z on inputs with in_valid=0 must not disturb the held outputs.
// TESTING
//   Each vector is applied with in_valid=1 and checked the cycle after out_valid rises.
//   1. A=0101,B=0011,Ci=1 -> S=1001, Co=0, PG=0, GG=0.
//   2. A=1100,B=1010,Ci=0 -> S=0110, Co=1, PG=0, GG=1.
//   3. A=0011,B=1111,Ci=1 -> S=0011, Co=1, PG=0, GG=1.
//   4. A=1010,B=0101,Ci=0 -> S=1111, Co=0, PG=1, GG=0.
//      Same operands with Ci=1 -> S=0000, Co=1, PG=1, GG=0.
//   5. Reset and hold:
//      - Assert rst_n=0 between clock edges -> all outputs 0 immediately.
//      - After release, in_valid=0 for 3 cycles -> outputs hold; out_valid=0.
//   6. Exhaustive sweep of all 512 {A,B,Ci} combinations -> {Co,S} == A+B+Ci,
//      and PG/GG match the equations above, each one cycle after capture.

Source files
------------

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice with one registered output stage.
// Exposes group propagate/generate so slices can sit under a second-level lookahead unit.
module cla4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co,
  output logic       PG,
  output logic       GG,
  output logic       out_valid
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic [3:0] sum_comb;
  logic       co_comb;
  logic       pg_comb;
  logic       gg_comb;

  logic [3:0] s_d,  s_q;
  logic       co_d, co_q;
  logic       pg_d, pg_q;
  logic       gg_d, gg_q;
  logic       out_valid_d, out_valid_q;

  // Every carry is a flat sum-of-products of p/g/Ci so no bit waits on its neighbour.
  always_comb begin
    p = A ^ B;
    g = A & B;

    c[0] = Ci;
    c[1] = g[0] | (p[0] & Ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Ci);

    co_comb = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Ci);

    pg_comb = p[3] & p[2] & p[1] & p[0];
    gg_comb = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    sum_comb = p ^ c;
  end

  // Without a capture the mux selects the held value, so undriven operands cannot leak through.
  always_comb begin
    s_d         = s_q;
    co_d        = co_q;
    pg_d        = pg_q;
    gg_d        = gg_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d  = sum_comb;
      co_d = co_comb;
      pg_d = pg_comb;
      gg_d = gg_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= 4'b0000;
      co_q        <= 1'b0;
      pg_q        <= 1'b0;
      gg_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      co_q        <= co_d;
      pg_q        <= pg_d;
      gg_q        <= gg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign Co        = co_q;
  assign PG        = pg_q;
  assign GG        = gg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla4.sv
// Self-checking bench for cla4: fixed vectors, reset/hold sequences and a full operand sweep.
// Expected results queue up as operands are issued and are compared when out_valid shows.
module tb_cla4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Ci;
  logic [3:0] S;
  logic       Co;
  logic       PG;
  logic       GG;
  logic       out_valid;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic       pg;
    logic       gg;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] res;
  } exp_t;

  vec_t tbl[5];
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  cla4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .S         (S),
    .Co        (Co),
    .PG        (PG),
    .GG        (GG),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition; group generate is the carry-out with Ci forced to 0.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] sum;
    logic [4:0] sum_nc;
    logic       pg;
    sum    = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    sum_nc = {1'b0, a} + {1'b0, b};
    pg     = ((a ^ b) == 4'hF);
    return {sum[4], sum[3:0], pg, sum_nc[4]};
  endfunction

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [6:0] exp, input string name);
    exp_t e;
    A        = a;
    B        = b;
    Ci       = ci;
    in_valid = 1'b1;
    e.name   = name;
    e.res    = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending result");
      end else begin
        e = sb.pop_front();
        check(e.name, {1'b0, Co, S, PG, GG}, {1'b0, e.res});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{a: 4'b0101, b: 4'b0011, ci: 1'b1, s: 4'b1001, co: 1'b0, pg: 1'b0, gg: 1'b0};
    tbl[1] = '{a: 4'b1100, b: 4'b1010, ci: 1'b0, s: 4'b0110, co: 1'b1, pg: 1'b0, gg: 1'b1};
    tbl[2] = '{a: 4'b0011, b: 4'b1111, ci: 1'b1, s: 4'b0011, co: 1'b1, pg: 1'b0, gg: 1'b1};
    tbl[3] = '{a: 4'b1010, b: 4'b0101, ci: 1'b0, s: 4'b1111, co: 1'b0, pg: 1'b1, gg: 1'b0};
    tbl[4] = '{a: 4'b1010, b: 4'b0101, ci: 1'b1, s: 4'b0000, co: 1'b1, pg: 1'b1, gg: 1'b0};

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 4'h0;
    B        = 4'h0;
    Ci       = 1'b0;

    #3;
    check("reset_state", {2'b00, out_valid, Co, S}, 8'h00);
    check("reset_pg_gg", {6'b0, PG, GG}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++)
      issue(tbl[i].a, tbl[i].b, tbl[i].ci,
            {tbl[i].co, tbl[i].s, tbl[i].pg, tbl[i].gg}, $sformatf("table_%0d", i));
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset lands between edges while a new capture is pending; that capture must vanish.
    issue(4'hF, 4'hF, 1'b1, {1'b1, 4'hF, 1'b0, 1'b1}, "max_sum");
    A  = 4'h9;
    B  = 4'h6;
    Ci = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", {2'b00, out_valid, Co, S}, 8'h00);
    check("async_reset_pg_gg", {6'b0, PG, GG}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("held_in_reset", {1'b0, out_valid, Co, S, PG}, 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("no_capture_after_reset", {2'b00, out_valid, Co, S}, 8'h00);

    issue(4'b1100, 4'b1010, 1'b0, {1'b1, 4'b0110, 1'b0, 1'b1}, "hold_load");
    in_valid = 1'b0;
    A        = 'x;
    B        = 'x;
    Ci       = 1'bx;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_%0d", k), {out_valid, Co, S, PG, GG}, {1'b0, 1'b1, 4'b0110, 1'b0, 1'b1});
      A = 4'(k * 5 + 3);
      B = 4'(k * 7 + 1);
      Ci = k[0];
    end

    for (int v = 0; v < 512; v++) begin
      logic [8:0] op;
      op = 9'(v);
      issue(op[8:5], op[4:1], op[0], model(op[8:5], op[4:1], op[0]), $sformatf("sweep_%0d", v));
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
